rr_onehot_arbiter: RTL
======================

RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of requesters, legal range 2..16.
REQ-002 The block SHALL have parameter HOLD_MAX, default 3, meaning the maximum consecutive cycles one requester keeps the grant while others wait, legal range 1..255.
REQ-003 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1, arbitration enable.
REQ-006 The block SHALL have port req, input, WIDTH, per-requester request, held high while service is wanted.
REQ-007 The block SHALL have port grant, output, WIDTH, registered zero-or-one-hot grant vector, feeding the downstream zero-one-hot checker test_expr.
REQ-008 The block SHALL have port grant_valid, output, 1, registered OR of grant.
REQ-009 The block SHALL have port grant_id, output, clog2(WIDTH), registered binary index of the granted bit, 0 when grant is 0.
REQ-010 The block SHALL have port lock, input, 1, grant-lock request, present only when RR_ARB_LOCK_EN is defined.

Function
REQ-011 All outputs SHALL be registered, with one-cycle latency from req/enable to grant.
REQ-012 grant SHALL be zero or one-hot in every cycle, including reset exit.
REQ-013 Internal state SHALL be a priority pointer ptr (0..WIDTH-1), a hold counter hold_cnt (0..HOLD_MAX-1) and the current grant.
REQ-014 Search SHALL pick the first asserted req bit in circular order starting at ptr, wrapping from index WIDTH-1 to 0.
REQ-015 On a new grant to index k, ptr SHALL become (k+1) mod WIDTH and hold_cnt SHALL become 0.
REQ-016 If grant is non-zero, req[current] is 1 and hold_cnt < HOLD_MAX-1, the grant SHALL be held and hold_cnt incremented.
REQ-017 If req[current] is 1 and hold_cnt = HOLD_MAX-1, the block SHALL re-search from ptr; if no other bit is requesting, current SHALL be re-granted with hold_cnt 0.
REQ-018 If req[current] drops, the next cycle SHALL carry the search result, which may be 0.
REQ-019 With req all-zero, grant SHALL go to 0 next cycle and ptr SHALL be unchanged.
REQ-020 With enable = 0, grant SHALL be 0 next cycle, ptr frozen and hold_cnt cleared; enable overrides everything else.
REQ-021 Simultaneous drop of req[current] and assertion of another bit SHALL grant the new bit next cycle with no idle cycle.

Reset
REQ-022 Asserting reset low SHALL immediately, asynchronously, clear grant to 0, grant_valid to 0, grant_id to 0, ptr to 0 and hold_cnt to 0, including mid-hold.
REQ-023 After reset deasserts, the first grant SHALL occur at the first rising clock edge with enable = 1 and req non-zero.

Configuration
REQ-024 Macro RR_ARB_LOCK_EN defined: port lock SHALL exist; while lock = 1, grant non-zero and req[current] = 1, the grant SHALL be held regardless of HOLD_MAX and hold_cnt SHALL saturate at HOLD_MAX-1.
REQ-025 Macro RR_ARB_LOCK_EN undefined: port lock SHALL be absent and behaviour SHALL equal lock = 0.

Verification
REQ-026 WIDTH=4, HOLD_MAX=3, reset release with req=4'b0101 held: grant SHALL be 0001 for 3 cycles, then 0100 for 3 cycles, then 0001, and the sequence SHALL repeat.
REQ-027 req=4'b1000 granted, then req changes to 4'b1001 at hold_cnt=2: the next grant SHALL be 0001 (wrap to index 0), with grant_id=0.
REQ-028 req=4'b0010 alone held for 10 cycles: grant SHALL stay 0010 for all 10 cycles via re-grant, and grant_id SHALL stay 1.
REQ-029 enable drops to 0 mid-hold: grant SHALL be 0000 next cycle; after enable returns, arbitration SHALL resume from the frozen ptr.
REQ-030 reset asserted asynchronously between clock edges while grant=0100: all outputs SHALL be 0 before the next clock edge.
REQ-031 With RR_ARB_LOCK_EN defined, lock=1 and req=4'b0011, grant 0001: grant SHALL be held for 8 cycles, and 0010 SHALL be granted one cycle after lock drops at saturated hold_cnt; a zero-one-hot checker on grant SHALL never fire in any scenario.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// rr_onehot_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter with a registered one-hot grant and a bounded hold time.
// A granted requester keeps the grant for up to HOLD_MAX consecutive cycles
// while it keeps requesting. After that, the search for the next requester
// starts just past the last winner. If nobody else is asking, the same
// requester is granted again with a fresh hold window.
//
// Parameters:
//   WIDTH     - number of requesters (2..16)
//   HOLD_MAX  - maximum consecutive cycles one requester holds the grant (1..255)
//
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   enable      - arbitration enable; when low the grant is dropped and the
//                 priority pointer is frozen
//   req         - per-requester request vector, held high while service wanted
//   lock        - grant-lock request (only when RR_ARB_LOCK_EN is defined);
//                 keeps the current grant regardless of HOLD_MAX
//   grant       - registered zero-or-one-hot grant vector
//   grant_valid - registered OR of grant
//   grant_id    - registered binary index of the granted bit, 0 when idle
//
// Optional feature macro: RR_ARB_LOCK_EN (adds the lock port).
// ============================================================================
module rr_onehot_arbiter #(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         req,
`ifdef RR_ARB_LOCK_EN
    input  logic                     lock,
`endif
    output logic [WIDTH-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(WIDTH)-1:0] grant_id
);

    localparam int IW = $clog2(WIDTH);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [IW:0]   WIDTH_EXT = (IW+1)'(WIDTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);

    // Priority pointer: index where the next circular search begins.
    logic [IW-1:0] ptr;
    // Number of extra cycles the current winner has already been held.
    logic [HW-1:0] hold_cnt;

    logic             lock_active;
    logic             found;
    logic [IW-1:0]    found_idx;
    logic [IW:0]      cand_sum;
    logic [IW-1:0]    cand;
    logic [WIDTH-1:0] grant_nxt;
    logic [IW-1:0]    id_nxt;
    logic [IW-1:0]    ptr_nxt;
    logic [HW-1:0]    hold_nxt;

    // Without the lock feature the block behaves exactly as if lock were
    // tied low, so the rest of the logic only ever looks at lock_active.
`ifdef RR_ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // Circular first-one search starting at ptr. The candidate index is
    // ptr + i folded back into 0..WIDTH-1, with one extra bit of headroom so
    // that non-power-of-two widths wrap correctly.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand_sum = {1'b0, ptr} + (IW+1)'(i);
            if (cand_sum >= WIDTH_EXT) begin
                cand_sum = cand_sum - WIDTH_EXT;
            end
            cand = cand_sum[IW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    // Next-state decision. Priority order: enable low forces idle, then a
    // still-requesting winner is kept while its hold window (or the lock)
    // allows, otherwise the search result wins. When the winner's window has
    // expired it is still requesting, so the search always finds someone,
    // possibly the same requester. That gives the re-grant with a fresh
    // window.
    always_comb begin
        grant_nxt = '0;
        id_nxt    = '0;
        ptr_nxt   = ptr;
        hold_nxt  = '0;
        if (!enable) begin
            grant_nxt = '0;
        end else if (grant_valid && req[grant_id] &&
                     (lock_active || (hold_cnt < HOLD_LAST))) begin
            grant_nxt = grant;
            id_nxt    = grant_id;
            hold_nxt  = (hold_cnt < HOLD_LAST) ? hold_cnt + 1'b1 : hold_cnt;
        end else if (found) begin
            grant_nxt = WIDTH'(1) << found_idx;
            id_nxt    = found_idx;
            ptr_nxt   = (found_idx == LAST_IDX) ? '0 : found_idx + 1'b1;
        end
    end

    // State and output registers. All outputs come straight from flops.
    // Reset clears everything asynchronously, even in the middle of a hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_id    <= id_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

endmodule
